// File: rtl/image_pkg.sv
// Types and widths shared by the sprite image loader and the sprite renderer.
package image_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PALETTE = 2'd1,
    IMAGE   = 2'd2,
    DONE    = 2'd3
  } load_state_t;

  localparam int COLOR_ID_WIDTH          = 8;
  localparam int COLOR_WIDTH             = 24;
  localparam int PALETTE_BYTES_PER_ENTRY = 3;

  // States in which the loader consumes stream bytes.
  function automatic logic is_load_state(input load_state_t state);
    return (state == PALETTE) || (state == IMAGE);
  endfunction

endpackage

// File: rtl/rgb_byte_packer.sv
// Packs three accepted stream bytes (R, G, B) into one palette word; the
// strobe fires combinationally on the accept of the blue byte.
module rgb_byte_packer
  import image_pkg::*;
(
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   clear,
  input  logic                   accept,
  input  logic [7:0]             byte_in,
  output logic [COLOR_WIDTH-1:0] word_out,
  output logic                   word_strobe
);

  localparam logic [1:0] LAST_PHASE = 2'(PALETTE_BYTES_PER_ENTRY - 1);

  logic [1:0] phase_reg;

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      phase_reg <= '0;
    end else if (accept) begin
      phase_reg <= (phase_reg == LAST_PHASE) ? 2'd0 : phase_reg + 2'd1;
    end
  end

  // One latch per leading colour channel; blue is taken straight from byte_in.
  genvar gi;
  generate
    for (gi = 0; gi < PALETTE_BYTES_PER_ENTRY - 1; gi++) begin : g_chan
      logic [7:0] chan_reg;
      always_ff @(posedge clk) begin
        if (srst || clear) begin
          chan_reg <= '0;
        end else if (accept && (phase_reg == 2'(gi))) begin
          chan_reg <= byte_in;
        end
      end
    end
  endgenerate

  assign word_out    = {g_chan[0].chan_reg, g_chan[1].chan_reg, byte_in};
  assign word_strobe = accept && (phase_reg == LAST_PHASE);

endmodule

// File: rtl/image_loader.sv
// Streams a palette block then an image block from a byte source into the
// sprite palette and image BRAM write ports, one byte per cycle.
module image_loader
  import image_pkg::*;
#(
  parameter int WIDTH         = 256,
  parameter int HEIGHT        = 256,
  parameter int PALETTE_DEPTH = 256
) (
  input  logic                              pixel_clk_in,
  input  logic                              rst_in,
  input  logic                              start_in,
  input  logic [7:0]                        byte_in,
  input  logic                              byte_valid_in,
  output logic                              byte_ready_out,
  output logic [7:0]                        palette_addr_out,
  output logic [COLOR_WIDTH-1:0]            palette_data_out,
  output logic                              palette_we_out,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]   image_addr_out,
  output logic [COLOR_ID_WIDTH-1:0]         image_data_out,
  output logic                              image_we_out,
  output logic                              busy_out,
  output logic                              done_out
);

  localparam int PIX_COUNT = WIDTH * HEIGHT;
  localparam int PIX_AW    = $clog2(PIX_COUNT);

  localparam logic [7:0]        LAST_ENTRY = 8'(PALETTE_DEPTH - 1);
  localparam logic [PIX_AW-1:0] LAST_PIXEL = PIX_AW'(PIX_COUNT - 1);

  load_state_t state_reg, state_next;

  logic [7:0]                entry_reg;
  logic [PIX_AW-1:0]         pixel_reg;
  logic                      pal_we_reg;
  logic [7:0]                pal_addr_reg;
  logic [COLOR_WIDTH-1:0]    pal_data_reg;
  logic                      img_we_reg;
  logic [PIX_AW-1:0]         img_addr_reg;
  logic [COLOR_ID_WIDTH-1:0] img_data_reg;

  logic                   byte_ready;
  logic                   accept;
  logic                   load_clear;
  logic                   pal_accept;
  logic                   img_accept;
  logic [COLOR_WIDTH-1:0] packed_word;
  logic                   packed_strobe;

  assign byte_ready = is_load_state(state_reg);
  assign accept     = byte_valid_in && byte_ready;
  assign load_clear = (state_reg == IDLE) && start_in;
  assign pal_accept = accept && (state_reg == PALETTE);
  assign img_accept = accept && (state_reg == IMAGE);

  rgb_byte_packer u_packer (
    .clk         (pixel_clk_in),
    .srst        (rst_in),
    .clear       (load_clear),
    .accept      (pal_accept),
    .byte_in     (byte_in),
    .word_out    (packed_word),
    .word_strobe (packed_strobe)
  );

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (start_in) state_next = PALETTE;
      PALETTE: if (packed_strobe && (entry_reg == LAST_ENTRY)) state_next = IMAGE;
      IMAGE:   if (img_accept && (pixel_reg == LAST_PIXEL)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Write ports are registered: strobes last one cycle, address/data hold.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      entry_reg    <= '0;
      pixel_reg    <= '0;
      pal_we_reg   <= 1'b0;
      pal_addr_reg <= '0;
      pal_data_reg <= '0;
      img_we_reg   <= 1'b0;
      img_addr_reg <= '0;
      img_data_reg <= '0;
    end else begin
      pal_we_reg <= 1'b0;
      img_we_reg <= 1'b0;
      if (load_clear) begin
        entry_reg <= '0;
        pixel_reg <= '0;
      end
      if (packed_strobe) begin
        pal_we_reg   <= 1'b1;
        pal_addr_reg <= entry_reg;
        pal_data_reg <= packed_word;
        entry_reg    <= entry_reg + 8'd1;
      end
      if (img_accept) begin
        img_we_reg   <= 1'b1;
        img_addr_reg <= pixel_reg;
        img_data_reg <= byte_in;
        pixel_reg    <= pixel_reg + PIX_AW'(1);
      end
    end
  end

  assign byte_ready_out   = byte_ready;
  assign busy_out         = byte_ready;
  assign done_out         = (state_reg == DONE);
  assign palette_we_out   = pal_we_reg;
  assign palette_addr_out = pal_addr_reg;
  assign palette_data_out = pal_data_reg;
  assign image_we_out     = img_we_reg;
  assign image_addr_out   = img_addr_reg;
  assign image_data_out   = img_data_reg;

endmodule
